// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared definitions for the branch redirect controller.
// State encoding and default flush length.
package branch_redirect_ctrl_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_FLUSH    = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    REDIRECT = ST_REDIRECT,
    FLUSH    = ST_FLUSH
  } state_e;

  localparam int DEF_FLUSH_CYCLES = 2;

endpackage

// File: rtl/branch_redirect_ctrl_sat.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count: clear wins, then saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != {W{1'b1}}))
      cnt_d = cnt_q + W'(1);
  end

  // count register
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign q = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Redirects the PC after a taken EX branch and holds
// IF/ID and ID/EX flush for a fixed number of un-stalled cycles.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int CNT_W        = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Ex_Valid,
  input  logic             i_Branch_Taken,
  input  logic [XLEN-1:0]  iv_Target,
  input  logic             i_Stall,
  input  logic             i_Fetch_Ready,
  output logic             o_Pc_Sel,
  output logic [XLEN-1:0]  ov_Redirect_Pc,
  output logic             o_Flush_IF_ID,
  output logic             o_Flush_ID_EX,
  output logic             o_Busy,
  output logic             o_Misalign_Exc,
  output logic [CNT_W-1:0] ov_Redirect_Cnt
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic            mis_q, mis_d;
  logic            inc;
  logic            take;

  assign take = i_Ex_Valid & i_Branch_Taken & ~i_Stall;

  // next-state, target capture, flush countdown, misalign pulse
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    fcnt_d  = fcnt_q;
    mis_d   = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          if (iv_Target[1:0] == 2'b00) begin
            tgt_d   = iv_Target;
            inc     = 1'b1;
            state_d = REDIRECT;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      REDIRECT: begin
        if (i_Fetch_Ready) begin
          fcnt_d  = FCW'(FLUSH_CYCLES);
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!i_Stall) begin
          if (fcnt_q == FCW'(1))
            state_d = IDLE;
          else
            fcnt_d = fcnt_q - FCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (i_Rst) begin
      state_d = IDLE;
      tgt_d   = '0;
      fcnt_d  = '0;
      mis_d   = 1'b0;
      inc     = 1'b0;
    end
  end

  // state, target and flush counter registers
  always_ff @(posedge i_Clk) begin
    state_q <= state_d;
    tgt_q   <= tgt_d;
    fcnt_q  <= fcnt_d;
    mis_q   <= mis_d;
  end

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (i_Clk),
    .clr (i_Rst),
    .inc (inc),
    .q   (ov_Redirect_Cnt)
  );

  assign o_Pc_Sel       = (state_q == REDIRECT);
  assign o_Flush_IF_ID  = (state_q == REDIRECT) | (state_q == FLUSH);
  assign o_Flush_ID_EX  = o_Flush_IF_ID;
  assign o_Busy         = o_Flush_IF_ID;
  assign o_Misalign_Exc = mis_q;
  assign ov_Redirect_Pc = tgt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomised bench with a behavioural model of the redirect controller,
// plus directed scenarios with literal expectations.
module tb_branch_redirect_ctrl;

  localparam int XLEN = 32;
  localparam int FC   = 2;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst, ex_valid, taken, stall, fready;
  logic [XLEN-1:0] target;
  logic            pc_sel, fl_ifid, fl_idex, busy, mis;
  logic [XLEN-1:0] rpc;
  logic [CW-1:0]   rcnt;

  int checks = 0;
  int errors = 0;

  // behavioural model: waiting-for-fetch flag and remaining flush cycles
  bit              m_wait;
  int              m_left;
  logic [XLEN-1:0] m_pc;
  int              m_cnt;
  bit              m_mis;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(
    .XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(CW)
  ) dut (
    .i_Clk           (clk),
    .i_Rst           (rst),
    .i_Ex_Valid      (ex_valid),
    .i_Branch_Taken  (taken),
    .iv_Target       (target),
    .i_Stall         (stall),
    .i_Fetch_Ready   (fready),
    .o_Pc_Sel        (pc_sel),
    .ov_Redirect_Pc  (rpc),
    .o_Flush_IF_ID   (fl_ifid),
    .o_Flush_ID_EX   (fl_idex),
    .o_Busy          (busy),
    .o_Misalign_Exc  (mis),
    .ov_Redirect_Cnt (rcnt)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_wait = 0; m_left = 0; m_pc = '0; m_cnt = 0; m_mis = 0;
    end else begin
      m_mis = 0;
      if (m_wait) begin
        if (fready) begin
          m_wait = 0;
          m_left = FC;
        end
      end else if (m_left > 0) begin
        if (!stall) m_left--;
      end else if (ex_valid && taken && !stall) begin
        if (target % 4 == 0) begin
          m_pc   = target;
          m_wait = 1;
          m_cnt  = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
        end else begin
          m_mis = 1;
        end
      end
    end
  endtask

  task automatic compare_model();
    bit m_busy;
    m_busy = m_wait || (m_left > 0);
    chk("pc_sel", 64'(pc_sel), 64'(m_wait));
    chk("redirect_pc", 64'(rpc), 64'(m_pc));
    chk("flush_if_id", 64'(fl_ifid), 64'(m_busy));
    chk("flush_id_ex", 64'(fl_idex), 64'(m_busy));
    chk("busy", 64'(busy), 64'(m_busy));
    chk("misalign", 64'(mis), 64'(m_mis));
    chk("redirect_cnt", 64'(rcnt), 64'(m_cnt));
  endtask

  task automatic step(input logic r, input logic v, input logic t,
                      input logic [XLEN-1:0] tg, input logic s,
                      input logic f);
    rst = r; ex_valid = v; taken = t; target = tg; stall = s; fready = f;
    @(posedge clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic idle(input int n, input logic s, input logic f);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, s, f);
  endtask

  initial begin
    rst = 1; ex_valid = 0; taken = 0; target = '0; stall = 0; fready = 0;
    step(1, 0, 0, '0, 0, 0);
    step(1, 0, 0, '0, 0, 0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pc", 64'(rpc), 64'd0);
    chk("rst_cnt", 64'(rcnt), 64'd0);

    // single redirect with fetch ready
    step(0, 1, 1, 32'h100, 0, 1);
    chk("t1_pcsel", 64'(pc_sel), 64'd1);
    chk("t1_pc", 64'(rpc), 64'h100);
    chk("t1_cnt", 64'(rcnt), 64'd1);
    idle(1, 0, 1);
    chk("t1_f1_pcsel", 64'(pc_sel), 64'd0);
    chk("t1_f1_flush", 64'(fl_ifid), 64'd1);
    idle(1, 0, 1);
    chk("t1_f2_flush", 64'(fl_idex), 64'd1);
    idle(1, 0, 1);
    chk("t1_done", 64'(busy), 64'd0);

    // fetch not ready for 3 cycles, wrong-path branch ignored
    step(0, 1, 1, 32'h100, 0, 0);
    step(0, 1, 1, 32'h200, 0, 0);
    idle(1, 0, 0);
    chk("t2_pcsel_hold", 64'(pc_sel), 64'd1);
    chk("t5_pc_kept", 64'(rpc), 64'h100);
    idle(1, 0, 1);
    chk("t2_pcsel_drop", 64'(pc_sel), 64'd0);
    // stall 2 cycles in FLUSH
    idle(2, 1, 0);
    chk("t3_stalled", 64'(busy), 64'd1);
    idle(1, 0, 0);
    chk("t3_last", 64'(busy), 64'd1);
    step(0, 1, 1, 32'h200, 0, 0);
    chk("t5_cnt_kept", 64'(rcnt), 64'd2);
    chk("t3_done", 64'(busy), 64'd0);

    // misaligned target
    step(0, 1, 1, 32'h102, 0, 1);
    chk("t4_mis", 64'(mis), 64'd1);
    chk("t4_noflush", 64'(fl_ifid), 64'd0);
    chk("t4_cnt", 64'(rcnt), 64'd2);
    idle(1, 0, 1);
    chk("t4_pulse", 64'(mis), 64'd0);

    // reset mid-redirect, then saturation
    step(0, 1, 1, 32'h300, 0, 0);
    step(1, 0, 0, '0, 0, 0);
    chk("t6_rst_pcsel", 64'(pc_sel), 64'd0);
    chk("t6_rst_pc", 64'(rpc), 64'd0);
    chk("t6_rst_cnt", 64'(rcnt), 64'd0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 1, 32'h400 + 32'(k * 4), 0, 1);
      idle(3, 0, 1);
    end
    chk("t6_sat", 64'(rcnt), 64'd3);

    // randomised traffic
    for (int i = 0; i < 4000; i++) begin
      logic [XLEN-1:0] tg;
      tg = $urandom;
      if ($urandom_range(3) != 0) tg[1:0] = 2'b00;
      step(($urandom_range(99) == 0), 1'($urandom), 1'($urandom), tg,
           ($urandom_range(3) == 0), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
